// File: rtl/video_scale_pkg.sv
// Shared constants and default geometry for the video scaling blocks.
package video_scale_pkg;

  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned PIX_W       = 16;

  localparam logic [PIX_W-1:0] BLACK_565 = 16'h0000;

  // Default geometry: 320x180 source, 1280x720 output.
  localparam logic [10:0] DEF_SRC_WIDTH  = 11'd320;
  localparam logic [9:0]  DEF_SRC_HEIGHT = 10'd180;
  localparam logic [10:0] DEF_DST_WIDTH  = 11'd1280;
  localparam logic [9:0]  DEF_DST_HEIGHT = 10'd720;
  localparam int unsigned DEF_ADDR_W     = 9;

endpackage

// File: rtl/upsample_line_buf.sv
// Two-bank line buffer: simple dual-port RAM, one write port, one registered read port.
module upsample_line_buf
  import video_scale_pkg::*;
#(
  parameter int unsigned Depth = 320,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [AddrW-1:0] rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  // Storage is left unreset; every word is written before a full bank is ever read.
  logic [PIX_W-1:0] mem [2][Depth];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Read port, one cycle latency; data holds when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/video_upsampling_4x.sv
// 4x nearest-neighbour upscaler: 320x180 RGB565 source stream to 1280x720 output,
// with output timing slaved to an external tim_vs/tim_de generator.
module video_upsampling_4x
  import video_scale_pkg::*;
#(
  parameter logic [10:0] SRC_WIDTH  = DEF_SRC_WIDTH,
  parameter logic [9:0]  SRC_HEIGHT = DEF_SRC_HEIGHT,
  parameter logic [10:0] DST_WIDTH  = DEF_DST_WIDTH,
  parameter logic [9:0]  DST_HEIGHT = DEF_DST_HEIGHT,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [PIX_W-1:0] src_data,
  output logic             src_ready,
  input  logic             tim_vs,
  input  logic             tim_de,
  output logic             vs_out,
  output logic             de_out,
  output logic [PIX_W-1:0] rgb565_out,
  output logic             underrun
);

  if (int'(DST_WIDTH) != int'(SRC_WIDTH) * 4 || int'(DST_HEIGHT) != int'(SRC_HEIGHT) * 4 ||
      (1 << ADDR_W) < int'(SRC_WIDTH)) begin : g_bad_geometry
    $error("video_upsampling_4x: inconsistent geometry parameters");
  end

  // Control state
  logic              armed_q, armed_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [9:0]        y_q, y_d;
  logic              line_ok_q, line_ok_d;

  // Timing pipeline and output
  logic              vs_d1_q, vs_d2_q;
  logic              de_d1_q, de_d2_q;
  logic [10:0]       x_q, x_d, x_d1_q;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              underrun_q, underrun_d;

  logic              vs_rise, de_rise, de_fall;
  logic              wr_fire, wr_last, y_active, x_in_line, line_consume;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  assign vs_rise = vs_d1_q & ~vs_d2_q;
  // Line edges compare the live tim_de against its registered copy so line_ok is
  // settled before the first pixel reaches the output register.
  assign de_rise = tim_de & ~de_d1_q;
  assign de_fall = ~tim_de & de_d1_q;

  assign src_ready    = armed_q & ~bank_full_q[wr_bank_q] & ~vs_rise;
  assign wr_fire      = src_valid & src_ready;
  assign wr_last      = (wr_addr_q == ADDR_W'(SRC_WIDTH - 11'd1));
  assign y_active     = (y_q < DST_HEIGHT);
  assign x_in_line    = (x_q < DST_WIDTH);
  assign line_consume = de_fall & line_ok_q & (y_q[1:0] == 2'd3);

  // Past the end of the line x sits at DST_WIDTH; reads stop so no address beyond the line.
  assign rd_en   = tim_de & x_in_line;
  assign rd_addr = ADDR_W'(x_q >> SCALE_SHIFT);

  // Next-state for bank bookkeeping, write pointer and line counter; arm overrides all.
  always_comb begin
    armed_d     = armed_q;
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    y_d         = y_q;
    line_ok_d   = line_ok_q;

    if (wr_fire) begin
      if (wr_last) begin
        wr_addr_d              = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    if (de_rise) begin
      line_ok_d = armed_q & y_active & bank_full_q[rd_bank_q];
    end

    if (de_fall) begin
      if (y_active) begin
        y_d = y_q + 10'd1;
      end
      // Write sets only an empty bank and this clears only a full one, so no collision.
      if (line_consume) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end

    if (vs_rise) begin
      armed_d     = 1'b1;
      bank_full_d = 2'b00;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_addr_d   = '0;
      y_d         = '0;
    end
  end

  // Column counter, underrun detect and output pixel selection.
  always_comb begin
    x_d = '0;
    if (tim_de) begin
      x_d = x_in_line ? (x_q + 11'd1) : x_q;
    end
    underrun_d = de_rise & armed_q & y_active & ~bank_full_q[rd_bank_q];
    rgb_d      = BLACK_565;
    if (de_d1_q && line_ok_q && (x_d1_q < DST_WIDTH)) begin
      rgb_d = rd_data;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed_q     <= 1'b0;
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      y_q         <= '0;
      line_ok_q   <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      y_q         <= y_d;
      line_ok_q   <= line_ok_d;
    end
  end

  // Two-stage timing delay matching RAM read plus output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      de_d1_q    <= 1'b0;
      de_d2_q    <= 1'b0;
      x_q        <= '0;
      x_d1_q     <= '0;
      rgb_q      <= BLACK_565;
      underrun_q <= 1'b0;
    end else begin
      vs_d1_q    <= tim_vs;
      vs_d2_q    <= vs_d1_q;
      de_d1_q    <= tim_de;
      de_d2_q    <= de_d1_q;
      x_q        <= x_d;
      x_d1_q     <= x_q;
      rgb_q      <= rgb_d;
      underrun_q <= underrun_d;
    end
  end

  assign vs_out     = vs_d2_q;
  assign de_out     = de_d2_q;
  assign rgb565_out = rgb_q;
  assign underrun   = underrun_q;

  upsample_line_buf #(
    .Depth(int'(SRC_WIDTH)),
    .AddrW(ADDR_W)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_bank(wr_bank_q),
    .wr_addr(wr_addr_q),
    .wr_data(src_data),
    .rd_en  (rd_en),
    .rd_bank(rd_bank_q),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_video_upsampling_4x.sv
// Self-checking bench for video_upsampling_4x against a line-queue reference model.
module tb_video_upsampling_4x;
  import video_scale_pkg::*;

  localparam int SW = 320;
  localparam int DW = 1280;
  localparam int DH = 720;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        tim_vs;
  logic        tim_de;
  logic        vs_out;
  logic        de_out;
  logic [15:0] rgb565_out;
  logic        underrun;

  always #5 clk = ~clk;

  video_upsampling_4x dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .tim_vs    (tim_vs),
    .tim_de    (tim_de),
    .vs_out    (vs_out),
    .de_out    (de_out),
    .rgb565_out(rgb565_out),
    .underrun  (underrun)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: completed source lines in arrival order, plus the line being filled.
  bit          m_armed;
  int          m_y;
  logic [15:0] m_full[$];
  logic [15:0] m_part[$];
  int          pat_idx;

  logic [15:0] cap_pix[1300];
  logic        cap_rdy[1300];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_y = 0;
    m_full.delete();
    m_part.delete();
  endtask

  task automatic model_push(input logic [15:0] d);
    m_part.push_back(d);
    if (m_part.size() == SW) begin
      foreach (m_part[k]) m_full.push_back(m_part[k]);
      m_part.delete();
    end
  endtask

  function automatic logic [15:0] pat_val(input int idx);
    return 16'(((idx / SW) << 8) + (idx % SW));
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b0;
    src_valid = 1'b0;
    src_data = '0;
    tim_vs = 1'b0;
    tim_de = 1'b0;
    repeat (n) tick();
    check_eq("rst_src_ready", src_ready, 0);
    check_eq("rst_vs_out", vs_out, 0);
    check_eq("rst_de_out", de_out, 0);
    check_eq("rst_rgb", rgb565_out, 0);
    check_eq("rst_underrun", underrun, 0);
    rst = 1'b1;
    m_armed = 1'b0;
    model_clear();
  endtask

  task automatic do_arm();
    tim_vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("arm_vs_out", vs_out, (i > 0));
      check_eq("arm_src_ready", src_ready, (i > 0));
    end
    tim_vs = 1'b0;
    m_armed = 1'b1;
    model_clear();
    tick();
    tick();
    check_eq("vs_out_fall", vs_out, 0);
  endtask

  // Offer up to n pixels within budget cycles; src_ready is tracked against the model.
  task automatic push_pix(input int n, input bit pattern, input bit gaps, input int budget,
                          output int acc);
    int          rdy_err;
    logic [15:0] d;
    bit          v;
    bit          fire;
    bit          exp_rdy;
    acc = 0;
    rdy_err = 0;
    d = pattern ? pat_val(pat_idx) : 16'($urandom);
    for (int c = 0; c < budget && acc < n; c++) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_valid = v;
      src_data = d;
      exp_rdy = m_armed && (m_full.size() < 2 * SW);
      if (src_ready !== exp_rdy) rdy_err++;
      fire = v && src_ready;
      tick();
      if (fire) begin
        model_push(d);
        acc++;
        if (pattern) pat_idx++;
        d = pattern ? pat_val(pat_idx) : 16'($urandom);
      end
    end
    src_valid = 1'b0;
    check_eq("src_ready_track", rdy_err, 0);
  endtask

  // One output line of n_de enable cycles plus a short blanking tail.
  task automatic run_line(input int n_de, input bit chk_und);
    int          errs_pix;
    int          errs_de;
    int          und_cnt;
    bit          ok;
    bit          exp_und;
    bit          exp_de;
    logic [15:0] exp_pix;
    errs_pix = 0;
    errs_de = 0;
    und_cnt = 0;
    ok = m_armed && (m_y < DH) && (m_full.size() >= SW);
    exp_und = m_armed && (m_y < DH) && !ok;
    src_valid = 1'b0;
    for (int i = 0; i < n_de + 4; i++) begin
      tim_de = (i < n_de);
      tick();
      cap_rdy[i] = src_ready;
      if (underrun) und_cnt++;
      if (chk_und && i == 0) check_eq("underrun_at_start", underrun, exp_und);
      // The sample after edge i+1 reflects tim_de driven at step i-1.
      exp_de = (i >= 1) && (i - 1 < n_de);
      exp_pix = (exp_de && ok && (i - 1) < DW) ? m_full[(i - 1) >> 2] : BLACK_565;
      if (de_out !== exp_de) errs_de++;
      if (i >= 1) cap_pix[i - 1] = rgb565_out;
      if (rgb565_out !== exp_pix) begin
        errs_pix++;
        if (errs_pix == 1) check_eq("first_bad_pixel", rgb565_out, exp_pix);
      end
    end
    check_eq("de_out_errors", errs_de, 0);
    check_eq("pixel_errors", errs_pix, 0);
    if (chk_und) check_eq("underrun_count", und_cnt, exp_und);
    if (ok && (m_y % 4 == 3)) begin
      for (int k = 0; k < SW; k++) void'(m_full.pop_front());
    end
    if (m_y < DH) m_y++;
  endtask

  initial begin
    int acc;
    int nz;

    // Reset, then idle without arm.
    do_reset(5);
    repeat (3) tick();
    check_eq("unarmed_src_ready", src_ready, 0);
    check_eq("unarmed_rgb", rgb565_out, 0);

    do_arm();

    // Backpressure: continuous valid with no output lines accepts exactly two lines.
    pat_idx = 0;
    push_pix(700, 1'b1, 1'b0, 700, acc);
    check_eq("bp_accepted", acc, 640);
    check_eq("bp_src_ready_low", src_ready, 0);

    // Basic upscale: 8 output lines from the two pattern lines.
    for (int ln = 0; ln < 8; ln++) begin
      run_line(DW, 1'b1);
      if (ln == 0) begin
        check_eq("l0_pix0", cap_pix[0], 16'h0000);
        check_eq("l0_pix3", cap_pix[3], 16'h0000);
        check_eq("l0_pix4", cap_pix[4], 16'h0001);
        check_eq("l0_pix1279", cap_pix[1279], 16'h013F);
      end
      if (ln == 3) begin
        check_eq("bp_ready_before_end", cap_rdy[DW - 1], 0);
        check_eq("bp_ready_after_end", cap_rdy[DW], 1);
      end
      if (ln == 4) begin
        check_eq("l4_pix0", cap_pix[0], 16'h0100);
        check_eq("l4_pix1279", cap_pix[1279], 16'h023F);
      end
    end

    // Underrun: no data buffered; the following pushed line must still be read normally.
    run_line(DW, 1'b1);
    push_pix(SW, 1'b0, 1'b0, 400, acc);
    check_eq("push_after_underrun", acc, SW);
    run_line(DW + 10, 1'b1);
    nz = 0;
    for (int k = DW; k < DW + 10; k++) if (cap_pix[k] != 16'h0000) nz++;
    check_eq("long_de_tail_black", nz, 0);
    run_line(DW, 1'b1);
    run_line(DW, 1'b1);

    // Mid-frame re-arm discards a partial line.
    push_pix(100, 1'b0, 1'b0, 200, acc);
    do_arm();
    push_pix(SW, 1'b0, 1'b1, 2000, acc);
    check_eq("rearm_accepted", acc, SW);
    for (int ln = 0; ln < 4; ln++) run_line(DW, 1'b1);

    // Randomized producer bursts interleaved with output lines.
    for (int it = 0; it < 8; it++) begin
      push_pix($urandom_range(0, 400), 1'b0, 1'b1, 1200, acc);
      run_line($urandom_range(DW - 4, DW + 6), 1'b1);
    end

    // Reset mid-frame: back to idle, output black until re-armed.
    push_pix(50, 1'b0, 1'b0, 100, acc);
    do_reset(3);
    tick();
    check_eq("post_rst_src_ready", src_ready, 0);
    run_line(DW, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
